tpum_apb_master: RTL

TPUM_APB_MASTER -- requirements
Module: tpum_apb_master

---
 rtl/tpum_apb_pkg.sv | 25 ++
 rtl/tpum_apb_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tpum_apb_pkg.sv
// rtl/tpum_apb_pkg.sv - shared types and constants for the APB burst master
package tpum_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDATA  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  localparam int unsigned BEAT_STRIDE = 4;

  // Register-file index map shared with the block's software-visible layout
  localparam int unsigned REG_CTRL_FIRST = 0;
  localparam int unsigned REG_CTRL_LAST  = 8;
  localparam int unsigned REG_TEMP_FIRST = 9;
  localparam int unsigned REG_TEMP_LAST  = 15;
  localparam int unsigned REG_R1_FIRST   = 16;
  localparam int unsigned REG_R1_LAST    = 47;
  localparam int unsigned REG_R2_FIRST   = 48;
  localparam int unsigned REG_R2_LAST    = 79;
  localparam int unsigned REG_RA_FIRST   = 80;
  localparam int unsigned REG_RA_LAST    = 111;

endpackage

// File: rtl/tpum_apb_master.sv
// rtl/tpum_apb_master.sv - APB burst master; ACCESS timeout enabled by TPUM_APB_TIMEOUT_EN
module tpum_apb_master
  import tpum_apb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int MAX_LEN_W      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [31:0]          wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_last,
  output logic                 apb_psel,
  output logic                 apb_penable,
  output logic                 apb_pwrite,
  output logic [ADDR_W-1:0]    apb_paddr,
  output logic [31:0]          apb_pwdata,
  input  logic [31:0]          apb_prdata,
  input  logic                 apb_pready,
  input  logic                 apb_pslverr
);

  state_e               state_q, state_d;
  logic                 gap_q, gap_d;
  logic                 write_q, write_d;
  logic [MAX_LEN_W-1:0] len_q, len_d;
  logic [MAX_LEN_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 wdata_ready_q, wdata_ready_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 tmo_hit;

`ifdef TPUM_APB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit   = (state_q == ST_ACCESS) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign tmo_cnt_d = (state_q == ST_ACCESS) ? tmo_cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    write_d     = write_q;
    len_d       = len_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ready_q && cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = '0;
          gap_d   = 1'b0;
          state_d = cmd_write ? ST_WDATA : ST_SETUP;
        end
      end
      ST_WDATA: begin
        if (wdata_valid) begin
          pwdata_d = wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // gap_q marks the idle cycle that separates consecutive read beats
        if (gap_q) gap_d = 1'b0;
        else       state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'd0 : apb_prdata;
          rsp_err_d   = apb_pslverr;
          rsp_last_d  = (beat_q == len_q);
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_W'(BEAT_STRIDE);
            beat_d = beat_q + 1'b1;
            if (write_q) begin
              state_d = ST_WDATA;
            end else begin
              state_d = ST_SETUP;
              gap_d   = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d   = (state_d == ST_IDLE);
    wdata_ready_d = (state_d == ST_WDATA);
    psel_d        = ((state_d == ST_SETUP) && !gap_d) || (state_d == ST_ACCESS);
    penable_d     = (state_d == ST_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gap_q         <= 1'b0;
      write_q       <= 1'b0;
      len_q         <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_last_q    <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wdata_ready_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      write_q       <= write_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_last_q    <= rsp_last_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_last    = rsp_last_q;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_pwrite  = write_q & psel_q;
  assign apb_paddr   = addr_q;
  assign apb_pwdata  = pwdata_q;

endmodule
